alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Second-generation execute-stage ALU. Combinational ALU path with extended op set,
//  signed SLT and overflow flag, plus an iterative multiply/divide unit writing HI/LO.
//  Sits in EX; the hazard unit stalls the pipeline on md_busy and on MFHI/MFLO while busy.
// PARAMETERS
//  WIDTH  32  datapath width; even, >= 4
// PORTS
//  clk          in   1        rising-edge clock, sole clock domain
//  reset_n      in   1        asynchronous active-low reset
//  srca         in   WIDTH    operand A (dividend / multiplicand)
//  srcb         in   WIDTH    operand B (divisor / multiplier)
//  alucontrol   in   4        combinational op select
//  aluout       out  WIDTH    combinational result
//  zero         out  1        aluout == 0
//  overflow     out  1        signed overflow of ADD/SUB, else 0
//  md_start     in   1        request muldiv op md_op on srca/srcb
//  md_op        in   3        000 MULT,001 MULTU,010 DIV,011 DIVU,100 MTHI,101 MTLO
//  md_flush     in   1        abort in-flight muldiv op
//  md_busy      out  1        iterative op in progress
//  md_done      out  1        one-cycle pulse: HI/LO just updated by MULT/DIV
//  hi, lo       out  WIDTH    HI/LO registers
// BEHAVIOUR
//  Reset (async, reset_n=0): hi=lo=0, md_busy=0, md_done=0, FSM=IDLE, iteration count=0.
//   Reset mid-operation abandons the op; no partial HI/LO write.
//  ALU (combinational; no clock dependency except via hi/lo):
//   0000 a&b  0001 a|b  0010 a+b  0011 a^b  0100 a&~b  0101 a|~b  0110 a-b
//   0111 signed a<b ->1/0  1000 unsigned a<b  1001 ~(a|b)  1010 hi  1011 lo
//   1100-1111 -> 0. Sums truncated to WIDTH. overflow only for 0010/0110.
//  FSM: IDLE -> RUN (on accepted MULT*/DIV*) -> DONE -> IDLE; DONE->RUN on a new start.
//   md_start accepted only when md_busy=0 (IDLE or DONE); ignored while busy.
//   MTHI/MTLO: hi/lo <= srca at that edge; no busy, no md_done; FSM unchanged.
//   MULT*/DIV*: md_busy=1 from the accept edge; WIDTH RUN cycles, one bit per cycle
//    (shift-add multiply; restoring divide on magnitudes, signs fixed up at the end).
//   After the WIDTH-th RUN cycle, hi/lo are written at the edge into DONE.
//    md_busy=0 and md_done=1 for exactly that DONE cycle.
//    Accept-to-md_done latency = WIDTH+1 edges.
//   MULT/MULTU: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
//   DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
//   Divide by zero: lo = all ones, hi = dividend. Same latency; no exception.
//   Signed overflow (min / -1): lo = min, hi = 0.
//   Operands are latched at accept; srca/srcb may change during RUN.
//  md_flush=1: next edge FSM=IDLE, md_busy=0, no md_done, hi/lo unchanged.
//   Flush and start in the same cycle: flush wins; start is dropped.
//  Reading alucontrol 1010/1011 while busy returns the old hi/lo (stalling is the
//   hazard unit's job).
// TESTING
//  ALU: a=0x7FFFFFFF, b=1, 0010 -> 0x80000000, overflow=1. 0111 with a=-1, b=1 -> 1.
//   1000 with the same operands -> 0. 0110 with a=b -> zero=1.
//  MULT a=-3, b=7 -> md_done 33 edges after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1.
//  DIV a=-7, b=2 -> lo=-3, hi=-1. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
//   DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
//  Start pulsed while busy is ignored. Start in the DONE cycle -> back-to-back op.
//   MTHI 0x1234 while idle -> hi=0x1234 next edge, md_done stays 0.
//  Flush at RUN cycle 10 -> md_busy low next edge, hi/lo hold prior values, no md_done.
//   reset_n low mid-RUN -> all outputs zero immediately.
//  Rerun the MULT/DIV checks at WIDTH=8 against a reference model.

Source files
------------

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv -- execute-stage ALU with an iterative multiply/divide unit.
//
// The ALU path is purely combinational. The multiply/divide unit retires one
// bit per clock over WIDTH RUN cycles and writes HI/LO on the edge into DONE.
// The hazard unit stalls on md_busy, so HI/LO reads while busy see old values.
//
// Ports
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   srca, srcb           operands (dividend/multiplicand, divisor/multiplier)
//   alucontrol           combinational op select
//   aluout, zero         combinational result and (aluout == 0)
//   overflow             signed overflow of ADD/SUB, else 0
//   md_start, md_op      start a muldiv op (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   md_flush             abort any in-flight muldiv op
//   md_busy, md_done     iterative op running / one-cycle HI/LO-updated pulse
//   hi, lo               HI/LO registers
// -----------------------------------------------------------------------------
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             overflow,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  input  logic             md_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // ---------------------------------------------------------------- ALU
  logic [WIDTH-1:0] w_sum, w_diff;
  assign w_sum  = srca + srcb;
  assign w_diff = srca - srcb;

  // NOTE: every output gets a default first, so no path through the case
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    aluout   = '0;
    overflow = 1'b0;
    case (alucontrol)
      4'b0000: aluout = srca & srcb;
      4'b0001: aluout = srca | srcb;
      4'b0010: begin
        aluout   = w_sum;
        overflow = (srca[WIDTH-1] == srcb[WIDTH-1]) && (w_sum[WIDTH-1] != srca[WIDTH-1]);
      end
      4'b0011: aluout = srca ^ srcb;
      4'b0100: aluout = srca & ~srcb;
      4'b0101: aluout = srca | ~srcb;
      4'b0110: begin
        aluout   = w_diff;
        overflow = (srca[WIDTH-1] != srcb[WIDTH-1]) && (w_diff[WIDTH-1] != srca[WIDTH-1]);
      end
      4'b0111: aluout = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      4'b1000: aluout = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      4'b1001: aluout = ~(srca | srcb);
      4'b1010: aluout = hi;
      4'b1011: aluout = lo;
      default: aluout = '0;
    endcase
  end

  assign zero = (aluout == '0);

  // ---------------------------------------------------------------- MULDIV
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_is_div;   // 1: divide, 0: multiply
  logic [WIDTH-1:0] r_acc;      // product high half / partial remainder
  logic [WIDTH-1:0] r_q;        // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] r_opnd;     // multiplicand / divisor magnitude
  logic             r_neg_q;    // negate product or quotient at the end
  logic             r_neg_r;    // negate remainder (dividend was negative)
  logic             r_div0;     // divisor was zero

  // Both units work on magnitudes; signed ops just fold in a final negate.
  logic             w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_signed = ~md_op[0];
  assign w_a_neg  = w_signed & srca[WIDTH-1];
  assign w_b_neg  = w_signed & srcb[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -srca : srca;
  assign w_b_mag  = w_b_neg ? -srcb : srcb;

  // Shift-add multiply step: conditionally add, then shift {acc,q} right.
  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mul_acc, w_mul_q;
  assign w_madd    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_acc = w_madd[WIDTH:1];
  assign w_mul_q   = {w_madd[0], r_q[WIDTH-1:1]};

  // Restoring divide step: shift in next dividend bit, keep the difference
  // if it did not go negative (bit WIDTH of the difference is the borrow).
  logic [WIDTH:0]   w_dshift, w_dsub;
  logic             w_dge;
  logic [WIDTH-1:0] w_div_acc, w_div_q;
  assign w_dshift  = {r_acc, r_q[WIDTH-1]};
  assign w_dsub    = w_dshift - {1'b0, r_opnd};
  assign w_dge     = ~w_dsub[WIDTH];
  assign w_div_acc = w_dge ? w_dsub[WIDTH-1:0] : w_dshift[WIDTH-1:0];
  assign w_div_q   = {r_q[WIDTH-2:0], w_dge};

  logic [WIDTH-1:0] w_nx_acc, w_nx_q;
  assign w_nx_acc = r_is_div ? w_div_acc : w_mul_acc;
  assign w_nx_q   = r_is_div ? w_div_q   : w_mul_q;

  // Final sign fix-up, applied to the last step's result on the edge into DONE.
  // Divide by zero leaves the shifted-in dividend magnitude in acc, so the
  // remainder fix-up alone reproduces the dividend in HI; only LO is forced.
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem, w_fin_hi, w_fin_lo;
  assign w_prod   = {w_nx_acc, w_nx_q};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -w_nx_q : w_nx_q);
  assign w_rem    = r_neg_r ? -w_nx_acc : w_nx_acc;
  assign w_fin_hi = r_is_div ? w_rem : w_prod_s[2*WIDTH-1:WIDTH];
  assign w_fin_lo = r_is_div ? w_quo : w_prod_s[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opnd   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (md_flush) begin
        // Flush beats a same-cycle start; HI/LO are left untouched.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_state <= S_IDLE;
            if (md_start && !md_op[2]) begin
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_is_div <= md_op[1];
              r_acc    <= '0;
              r_q      <= w_a_mag;
              r_opnd   <= w_b_mag;
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_div0   <= md_op[1] && (srcb == '0);
            end else if (md_start && md_op == 3'b100) begin
              r_hi <= srca;
            end else if (md_start && md_op == 3'b101) begin
              r_lo <= srca;
            end
          end
          S_RUN: begin
            r_acc <= w_nx_acc;
            r_q   <= w_nx_q;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH-1)) begin
              r_hi    <= w_fin_hi;
              r_lo    <= w_fin_lo;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_cnt   <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign md_busy = r_busy;
  assign md_done = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv -- directed bench for alu_muldiv at WIDTH=32 and WIDTH=8.
// Expected HI/LO values are queued when an op is started and popped when the
// DUT pulses md_done. Expectations come from spec constants or from a model
// built on the simulator's own 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_muldiv;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk, reset_n;
  logic [31:0] srca, srcb, aluout, hi, lo;
  logic [3:0]  alucontrol;
  logic        zero, overflow, md_start, md_flush, md_busy, md_done;
  logic [2:0]  md_op;

  logic [7:0]  srca8, srcb8, aluout8, hi8, lo8;
  logic [3:0]  alucontrol8;
  logic        zero8, overflow8, md_start8, md_flush8, md_busy8, md_done8;
  logic [2:0]  md_op8;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] sb32[$];
  logic [63:0] sb8[$];

  alu_muldiv #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .srca(srca), .srcb(srcb),
    .alucontrol(alucontrol), .aluout(aluout), .zero(zero), .overflow(overflow),
    .md_start(md_start), .md_op(md_op), .md_flush(md_flush),
    .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo));

  alu_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .srca(srca8), .srcb(srcb8),
    .alucontrol(alucontrol8), .aluout(aluout8), .zero(zero8), .overflow(overflow8),
    .md_start(md_start8), .md_op(md_op8), .md_flush(md_flush8),
    .md_busy(md_busy8), .md_done(md_done8), .hi(hi8), .lo(lo8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference {hi,lo} for a w-bit muldiv op; only the low w bits of each half are used.
  function automatic logic [63:0] model(input int w, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub, p, h, l;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - longint'(64'd1 << w);
    if (ub[w-1]) sb = sb - longint'(64'd1 << w);
    h = '0;
    l = '0;
    case (op)
      OP_MULT:  begin p = sa * sb; h = (p >> w) & mask; l = p & mask; end
      OP_MULTU: begin p = ua * ub; h = (p >> w) & mask; l = p & mask; end
      OP_DIV, OP_DIVU: begin
        if (ub == 64'd0) begin
          h = ua;
          l = mask;
        end else if (op == OP_DIV) begin
          p = sa % sb; h = p & mask;
          p = sa / sb; l = p & mask;
        end else begin
          h = ua % ub;
          l = ua / ub;
        end
      end
      default: ;
    endcase
    return {h[31:0], l[31:0]};
  endfunction

  // Wait for md_done on one DUT; c0 = edges already seen since accept
  // (the accept edge counts as 1). Checks latency, busy and popped HI/LO.
  task automatic wait_done(input bit is8, input string tag, input int c0);
    int c;
    logic [63:0] exp;
    c = c0;
    while (!(is8 ? md_done8 : md_done) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({tag, " latency"}, 64'(c), is8 ? 64'd9 : 64'd33);
    check({tag, " busy@done"}, 64'(is8 ? md_busy8 : md_busy), 64'd0);
    if (is8) begin
      exp = sb8.pop_front();
      check({tag, " hilo"}, {24'd0, hi8, 24'd0, lo8}, exp);
    end else begin
      exp = sb32.pop_front();
      check({tag, " hilo"}, {hi, lo}, exp);
    end
  endtask

  // Start an op at the current (negedge) time; operands are scrambled after accept.
  task automatic start32(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    srca = a; srcb = b; md_op = op; md_start = 1'b1;
    sb32.push_back(exp);
    @(negedge clk);
    md_start = 1'b0;
    srca = $urandom;
    srcb = $urandom;
    check({tag, " busy"}, 64'(md_busy), 64'd1);
    wait_done(1'b0, tag, 1);
  endtask

  task automatic run32(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    @(negedge clk);
    start32(tag, op, a, b, exp);
  endtask

  task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    srca8 = a; srcb8 = b; md_op8 = op; md_start8 = 1'b1;
    sb8.push_back(model(8, op, {24'd0, a}, {24'd0, b}));
    @(negedge clk);
    md_start8 = 1'b0;
    srca8 = 8'($urandom);
    srcb8 = 8'($urandom);
    wait_done(1'b1, tag, 1);
  endtask

  task automatic alu(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_out, input logic exp_ov);
    @(negedge clk);
    alucontrol = ctl; srca = a; srcb = b;
    #1;
    check(tag, {aluout, overflow, zero}, {exp_out, exp_ov, (exp_out == 32'd0)});
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    reset_n = 1'b0;
    srca = '0; srcb = '0; alucontrol = '0; md_start = 1'b0; md_op = '0; md_flush = 1'b0;
    srca8 = '0; srcb8 = '0; alucontrol8 = '0; md_start8 = 1'b0; md_op8 = '0; md_flush8 = 1'b0;

    #2;
    check("reset state", {30'd0, md_busy, md_done, hi, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Combinational ALU
    alu("add ovf",  4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
    alu("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    alu("sltu",     4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    alu("sub zero", 4'b0110, 32'h55, 32'h55, 32'd0, 1'b0);
    alu("sub ovf",  4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
    alu("and",      4'b0000, 32'hF0F0, 32'hFF00, 32'h0000_F000, 1'b0);
    alu("or",       4'b0001, 32'hF0F0, 32'hFF00, 32'h0000_FFF0, 1'b0);
    alu("xor",      4'b0011, 32'hF0F0, 32'hFF00, 32'h0000_0FF0, 1'b0);
    alu("andn",     4'b0100, 32'hF0F0, 32'hFF00, 32'h0000_00F0, 1'b0);
    alu("orn",      4'b0101, 32'hF0F0, 32'hFF00, 32'hFFFF_F0FF, 1'b0);
    alu("nor",      4'b1001, 32'hF0F0, 32'hFF00, 32'hFFFF_000F, 1'b0);
    alu("op 1100",  4'b1100, 32'hF0F0, 32'hFF00, 32'd0, 1'b0);
    alucontrol8 = 4'b0010; srca8 = 8'h7F; srcb8 = 8'h01;
    #1;
    check("w8 add ovf", {aluout8, overflow8, zero8}, {8'h80, 1'b1, 1'b0});
    alucontrol8 = 4'b0000;

    // Spec multiply/divide vectors
    run32("mult -3*7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,        {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run32("multu max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run32("div -7/2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run32("divu 7/0",    OP_DIVU,  32'd7,         32'd0,        {32'h0000_0007, 32'hFFFF_FFFF});
    run32("div min/-1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    alu("read hi", 4'b1010, 32'd0, 32'd0, 32'h0000_0000, 1'b0);
    alu("read lo", 4'b1011, 32'd0, 32'd0, 32'h8000_0000, 1'b0);

    // Back-to-back: start issued in the DONE cycle
    run32("b2b first", OP_MULT, 32'd3, 32'd4, {32'd0, 32'd12});
    start32("b2b second", OP_DIV, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Start pulsed while busy is ignored
    @(negedge clk);
    srca = 32'd5; srcb = 32'd6; md_op = OP_MULTU; md_start = 1'b1;
    sb32.push_back(64'd30);
    @(negedge clk);
    md_start = 1'b0;
    repeat (4) @(negedge clk);
    srca = 32'd100; srcb = 32'd3; md_op = OP_DIVU; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    wait_done(1'b0, "start while busy", 6);
    @(negedge clk);
    check("no second op", {62'd0, md_busy, md_done}, 64'd0);

    // MTHI / MTLO
    @(negedge clk);
    srca = 32'h1234; md_op = OP_MTHI; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    check("mthi", {30'd0, md_busy, md_done, hi}, {32'd0, 32'h1234});
    srca = 32'h5678; md_op = OP_MTLO; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    check("mtlo", {30'd0, md_busy, md_done, lo}, {32'd0, 32'h5678});

    // Flush at RUN cycle 10, with a HI read while busy along the way
    @(negedge clk);
    srca = 32'd100; srcb = 32'd7; md_op = OP_DIV; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    repeat (8) @(negedge clk);
    alucontrol = 4'b1010;
    #1;
    check("hi read while busy", {31'd0, md_busy, aluout}, {32'd1, 32'h1234});
    @(negedge clk);
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    check("flush", {30'd0, md_busy, md_done, hi, lo}, {30'd0, 2'b00, 32'h1234, 32'h5678});
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (md_done) done_seen++;
    end
    check("flush no done", 64'(done_seen), 64'd0);

    // Flush and start together: start is dropped
    srca = 32'd9; srcb = 32'd9; md_op = OP_MULT; md_start = 1'b1; md_flush = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_flush = 1'b0;
    check("flush+start busy", 64'(md_busy), 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (md_done) done_seen++;
    end
    check("flush+start", {32'(done_seen), hi}, {32'd0, 32'h1234});

    // Random 32-bit ops against the model
    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = (i == 7) ? 32'd0 : $urandom;
      rop = 3'(i % 4);
      run32($sformatf("w32 rnd%0d op%0d", i, rop), rop, ra, rb, model(32, rop, ra, rb));
    end

    // WIDTH=8: corners plus random operands for every muldiv op
    for (int op = 0; op < 4; op++) begin
      run8($sformatf("w8 op%0d min/-1", op), 3'(op), 8'h80, 8'hFF);
      run8($sformatf("w8 op%0d x/0",    op), 3'(op), 8'h85, 8'h00);
      run8($sformatf("w8 op%0d ff*ff",  op), 3'(op), 8'hFF, 8'hFF);
      for (int i = 0; i < 10; i++) begin
        ra = $urandom;
        rb = $urandom;
        run8($sformatf("w8 op%0d a=%h b=%h", op, ra[7:0], rb[7:0]), 3'(op), ra[7:0], rb[7:0]);
      end
    end

    // Reset mid-RUN clears everything at once
    @(negedge clk);
    srca = 32'd77; srcb = 32'd3; md_op = OP_MULT; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", 64'(md_busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset mid-run", {30'd0, md_busy, md_done, hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("after reset idle", {30'd0, md_busy, md_done, hi}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
